// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tmds_pkg
// Purpose  : TMDS control tokens, token-to-ctrl mapping and aligner state enum,
//            shared by the encoder and decoder sides.
// Revision : 1.0 - initial release
// ============================================================================
package tmds_pkg;

    localparam logic [9:0] c_tok_00 = 10'h354;
    localparam logic [9:0] c_tok_01 = 10'h0AB;
    localparam logic [9:0] c_tok_10 = 10'h154;
    localparam logic [9:0] c_tok_11 = 10'h2AB;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } align_state_t;

    // Returns {hit, ctrl[1:0]}; hit is 0 for any non-token word.
    function automatic logic [2:0] tok_lookup(input logic [9:0] word);
        case (word)
            c_tok_00: return 3'b100;
            c_tok_01: return 3'b101;
            c_tok_10: return 3'b110;
            c_tok_11: return 3'b111;
            default:  return 3'b000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_word_decode.sv
`default_nettype none
// ============================================================================
// Module   : tmds_word_decode
// Purpose  : Combinational 10-bit TMDS word -> {is_ctl, ctrl, data} decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [9:0] i_word,
    output logic       o_is_ctl,
    output logic [1:0] o_ctrl,
    output logic [7:0] o_data
);

    logic [7:0] w_t;
    logic [6:0] w_x;

    assign {o_is_ctl, o_ctrl} = tok_lookup(i_word);

    // Undo the optional inversion, then the XOR/XNOR chain of the encoder.
    assign w_t    = i_word[9] ? ~i_word[7:0] : i_word[7:0];
    assign w_x    = w_t[7:1] ^ w_t[6:0];
    assign o_data = i_word[8] ? {w_x, w_t[0]} : {~w_x, w_t[0]};

endmodule
`default_nettype wire

// File: rtl/tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tmds_channel_decoder
// Purpose  : Single-channel TMDS word aligner (control-token hunt) and decoder.
//            Optional macro TMDS_DEC_ERR_EN adds o_err / o_err_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_RUN       = 16,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int LOSS_WORDS     = 65535
) (
    input  logic        i_pix_clk,
    input  logic        i_rst_n,
    input  logic [9:0]  i_raw,
    output logic [7:0]  o_data,
    output logic [1:0]  o_ctrl,
    output logic        o_de,
    output logic        o_aligned,
    output logic [3:0]  o_offset
`ifdef TMDS_DEC_ERR_EN
    ,
    output logic        o_err,
    output logic [15:0] o_err_cnt
`endif
);

    localparam logic [15:0] c_run_last  = 16'(LOCK_RUN - 1);
    localparam logic [15:0] c_srch_last = 16'(SEARCH_TIMEOUT - 1);
    localparam logic [15:0] c_loss_last = 16'(LOSS_WORDS - 1);

    align_state_t r_state;
    align_state_t w_state_nxt;

    logic [9:0]  r_prev;
    logic [3:0]  r_offset;
    logic [15:0] r_run;
    logic [15:0] r_wcnt;

    logic [19:0] w_window;
    logic [9:0]  w_word;
    logic        w_is_ctl;
    logic [1:0]  w_dec_ctrl;
    logic [7:0]  w_dec_data;

    logic        w_run_done;
    logic        w_cnt_hit;
    logic        w_advance;
    logic        w_locked;
    logic        w_de;
    logic        w_ctl_upd;

    // Stage 1: previous word; the window spans two words so any bit phase fits.
    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= i_raw;
        end
    end

    assign w_window = {i_raw, r_prev};
    assign w_word   = w_window[{1'b0, r_offset} +: 10];

    tmds_word_decode u_word_decode (
        .i_word   (w_word),
        .o_is_ctl (w_is_ctl),
        .o_ctrl   (w_dec_ctrl),
        .o_data   (w_dec_data)
    );

    assign w_run_done = w_is_ctl && (r_run == c_run_last);
    assign w_cnt_hit  = (r_state == ST_SEARCH) ? (r_wcnt == c_srch_last)
                                               : (r_wcnt == c_loss_last);
    assign w_advance  = (r_state == ST_SEARCH) && w_cnt_hit && !w_run_done;

    // Shared word counter: search dwell in SEARCH, loss timer in LOCKED.
    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run    <= '0;
            r_wcnt   <= '0;
            r_offset <= '0;
        end else if (w_run_done || w_cnt_hit) begin
            r_run  <= '0;
            r_wcnt <= '0;
            if (w_advance) begin
                r_offset <= (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
            end
        end else begin
            r_run  <= w_is_ctl ? r_run + 16'd1 : 16'd0;
            r_wcnt <= r_wcnt + 16'd1;
        end
    end

    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A run completing together with timer expiry keeps the lock.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SEARCH: if (w_run_done) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (w_cnt_hit && !w_run_done) w_state_nxt = ST_SEARCH;
            default:   w_state_nxt = ST_SEARCH;
        endcase
    end

    always_comb begin
        w_locked  = (r_state == ST_LOCKED);
        w_de      = w_locked && !w_is_ctl;
        w_ctl_upd = w_locked && w_is_ctl;
    end

    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data    <= '0;
            o_ctrl    <= '0;
            o_de      <= 1'b0;
            o_aligned <= 1'b0;
        end else begin
            o_de      <= w_de;
            o_aligned <= w_locked;
            if (w_de) begin
                o_data <= w_dec_data;
            end
            if (w_ctl_upd) begin
                o_ctrl <= w_dec_ctrl;
            end
        end
    end

    assign o_offset = r_offset;

`ifdef TMDS_DEC_ERR_EN
    logic [7:0] w_t;
    logic       w_err;

    assign w_t   = w_word[9] ? ~w_word[7:0] : w_word[7:0];
    assign w_err = w_de && ($countones(w_t[7:1] ^ w_t[6:0]) > 4);

    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err     <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            o_err <= w_err;
            if (w_err && (o_err_cnt != 16'hFFFF)) begin
                o_err_cnt <= o_err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmds_channel_decoder
// Purpose  : Self-checking bench: lock, decode round-trip via a TMDS encoder
//            model, lock loss, async reset and misaligned offset search.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_channel_decoder;

    localparam int LOCK_RUN       = 16;
    localparam int SEARCH_TIMEOUT = 32;
    localparam int LOSS_WORDS     = 100;
    // Word indices whose processing cycle is LOCKED, when words 1..LOCK_RUN are tokens.
    localparam int LS = LOCK_RUN + 1;
    localparam int LE = LS + LOSS_WORDS - 1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  raw   = '0;
    logic [7:0]  data;
    logic [1:0]  ctrl;
    logic        de;
    logic        aligned;
    logic [3:0]  offset;
`ifdef TMDS_DEC_ERR_EN
    logic        err;
    logic [15:0] err_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int n     = 0;
    int disp  = 0;
    int err_model = 0;
    logic [9:0] prev_w;
    logic [7:0] prev_pix;
    logic [7:0] exp_data;
    logic [1:0] exp_ctrl;
    logic [7:0] fixed_pix [4] = '{8'h55, 8'h00, 8'hFF, 8'hA3};

    always #5 clk = ~clk;

    tmds_channel_decoder #(
        .LOCK_RUN       (LOCK_RUN),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .LOSS_WORDS     (LOSS_WORDS)
    ) dut (
        .i_pix_clk (clk),
        .i_rst_n   (rst_n),
        .i_raw     (raw),
        .o_data    (data),
        .o_ctrl    (ctrl),
        .o_de      (de),
        .o_aligned (aligned),
        .o_offset  (offset)
`ifdef TMDS_DEC_ERR_EN
        ,
        .o_err     (err),
        .o_err_cnt (err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h (word %0d)", tag, obs, exp, n);
        end
    endtask

    // DVI/HDMI TMDS data encoder with running disparity.
    function automatic logic [9:0] tmds_encode(input logic [7:0] d);
        logic [8:0] qm;
        logic       use_xnor;
        int         n1q;
        int         n0q;
        use_xnor = ($countones(d) > 4) || (($countones(d) == 4) && !d[0]);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !use_xnor;
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (disp == 0 || n1q == n0q) begin
            disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
            return {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
        end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
            disp += (qm[8] ? 2 : 0) + (n0q - n1q);
            return {1'b1, qm[8], ~qm[7:0]};
        end else begin
            disp += (qm[8] ? 0 : -2) + (n1q - n0q);
            return {1'b0, qm[8], qm[7:0]};
        end
    endfunction

    // {is_token, ctrl}
    function automatic logic [2:0] tok_info(input logic [9:0] w);
        if (w == 10'h354) return 3'b100;
        if (w == 10'h0AB) return 3'b101;
        if (w == 10'h154) return 3'b110;
        if (w == 10'h2AB) return 3'b111;
        return 3'b000;
    endfunction

    function automatic int trans_cnt(input logic [9:0] w);
        logic [7:0] t;
        t = w[9] ? ~w[7:0] : w[7:0];
        return $countones(t[7:1] ^ t[6:0]);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        raw   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", data, 0);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_de", de, 0);
        chk("rst_aligned", aligned, 0);
        chk("rst_offset", offset, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        n         = 0;
        prev_w    = '0;
        prev_pix  = '0;
        exp_data  = '0;
        exp_ctrl  = '0;
        disp      = 0;
        err_model = 0;
    endtask

    // Drive one aligned (offset 0) word and check the outputs for the word before it.
    task automatic run_word(input logic [9:0] w, input logic [7:0] pix);
        int         m;
        bit         locked;
        bit         exp_de;
        logic [2:0] ti;
        raw = w;
        @(posedge clk);
        #1;
        n++;
        m      = n - 1;
        locked = (m >= LS) && (m <= LE);
        ti     = tok_info(prev_w);
        exp_de = locked && !ti[2];
        if (exp_de) exp_data = prev_pix;
        if (locked && ti[2]) exp_ctrl = ti[1:0];
        chk("de", de, exp_de);
        chk("aligned", aligned, locked);
        chk("data", data, exp_data);
        chk("ctrl", ctrl, exp_ctrl);
        chk("offset", offset, 0);
`ifdef TMDS_DEC_ERR_EN
        if (exp_de && trans_cnt(prev_w) > 4) begin
            err_model++;
            chk("err", err, 1);
        end else begin
            chk("err", err, 0);
        end
        chk("err_cnt", err_cnt, err_model);
`endif
        prev_w   = w;
        prev_pix = pix;
    endtask

    initial begin
        logic [7:0] pix;
        logic [9:0] tok;
        int         exp_off;
        bit         exp_lock;

        // Lock at offset 0, decode fixed + random data, then async reset mid-data.
        do_reset();
        for (int i = 1; i <= 50; i++) begin
            if (i <= 20) begin
                run_word(10'h354, 8'h00);
            end else if (i <= 24) begin
                pix = fixed_pix[i-21];
                run_word(tmds_encode(pix), pix);
            end else if (i == 27 || i == 31 || i == 35) begin
                run_word(10'h155, 8'hFF);
            end else begin
                pix = 8'($urandom);
                run_word(tmds_encode(pix), pix);
            end
        end
`ifdef TMDS_DEC_ERR_EN
        chk("err_cnt_three", err_cnt, 3);
`endif
        #3;
        chk("pre_rst_aligned", aligned, 1);
        chk("pre_rst_de", de, 1);
        rst_n = 1'b0;
        #1;
        chk("async_data", data, 0);
        chk("async_ctrl", ctrl, 0);
        chk("async_de", de, 0);
        chk("async_aligned", aligned, 0);
        chk("async_offset", offset, 0);
`ifdef TMDS_DEC_ERR_EN
        chk("async_err_cnt", err_cnt, 0);
`endif

        // Fresh run needed to relock; short token burst mid-data; lock loss.
        do_reset();
        for (int i = 1; i <= 125; i++) begin
            if (i <= 20) begin
                run_word(10'h154, 8'h00);
            end else if (i >= 40 && i <= 42) begin
                run_word(10'h0AB, 8'h00);
            end else begin
                pix = 8'($urandom);
                run_word(tmds_encode(pix), pix);
            end
        end

        // Token 0x2AB arriving 7 bits late: offset walks 0..7 then locks.
        do_reset();
        tok = 10'h2AB;
        for (int i = 1; i <= 270; i++) begin
            raw = (i == 1) ? {tok[2:0], 7'b0} : {tok[2:0], tok[9:3]};
            @(posedge clk);
            #1;
            n++;
            exp_off  = (n / SEARCH_TIMEOUT > 7) ? 7 : n / SEARCH_TIMEOUT;
            exp_lock = (n >= 7 * SEARCH_TIMEOUT + LOCK_RUN + 1);
            chk("srch_offset", offset, 16'(exp_off));
            chk("srch_aligned", aligned, exp_lock);
            chk("srch_ctrl", ctrl, exp_lock ? 16'd3 : 16'd0);
            chk("srch_de", de, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
